// File: rtl/wb_stream_pkg.sv
// Shared definitions for the Wishbone stream-writer DMA path.
package wb_stream_pkg;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Wishbone burst type extension: linear bursts only
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Burst controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time width calculation; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst-read DMA engine: memory buffer -> stream FIFO.
// Issues one incrementing burst at a time, sized to fit the FIFO free space.
module wb_stream_writer_ctrl
  import wb_stream_pkg::*;
#(
  parameter int unsigned WB_AW         = 32,
  parameter int unsigned WB_DW         = 32,
  parameter int unsigned FIFO_AW       = 4,
  parameter int unsigned MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic                 wbm_rty_i,
  output logic [WB_DW-1:0]     fifo_d,
  output logic                 fifo_wr,
  input  logic [FIFO_AW:0]     fifo_cnt,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic                 busy,
  output logic                 done,
  output logic [WB_DW-1:0]     tx_cnt
);

  localparam int unsigned STEP       = WB_DW / 8;
  localparam int unsigned STEP_SH    = clog2(STEP);
  localparam int unsigned BL_W       = clog2(MAX_BURST_LEN + 1);
  localparam int unsigned FIFO_DEPTH = 2**FIFO_AW;
  localparam int unsigned CNT_W      = FIFO_AW + 1;

  state_e             state_q, state_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_AW-1:0]   start_q, start_d;
  logic [WB_AW-1:0]   size_q, size_d;
  logic [WB_AW-1:0]   burst_q, burst_d;
  logic [BL_W-1:0]    beat_q, beat_d;
  logic [WB_DW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]         cti_q, cti_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WB_AW-1:0]   eff_burst_c;
  logic [WB_AW-1:0]   remain_c;
  logic [WB_AW-1:0]   len_c;
  logic [WB_AW-1:0]   free_c;
  logic [WB_DW-1:0]   tx_inc_c;
  logic               ack_beat_c;
  logic               err_beat_c;

  // Retry is not acted on: stb is simply held until ack or err
  logic unused_rty;
  assign unused_rty = wbm_rty_i;

  // Requested burst length clamped to 1..MAX_BURST_LEN
  always_comb begin
    if (burst_size == '0) begin
      eff_burst_c = WB_AW'(1);
    end else if (burst_size > WB_AW'(MAX_BURST_LEN)) begin
      eff_burst_c = WB_AW'(MAX_BURST_LEN);
    end else begin
      eff_burst_c = burst_size;
    end
  end

  // Next burst length and FIFO headroom
  always_comb begin
    remain_c = size_q - WB_AW'(tx_cnt_q);
    len_c    = (burst_q < remain_c) ? burst_q : remain_c;
    free_c   = WB_AW'(CNT_W'(FIFO_DEPTH) - fifo_cnt);
    tx_inc_c = tx_cnt_q + WB_DW'(1);
  end

  // Beat qualification; a simultaneous err wins over ack and reset blocks writes
  assign ack_beat_c = (state_q == ST_BURST) && cyc_q && stb_q && wbm_ack_i &&
                      !wbm_err_i && !wb_rst_i;
  assign err_beat_c = (state_q == ST_BURST) && cyc_q && stb_q && wbm_err_i;

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    start_d  = start_q;
    size_d   = size_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    tx_cnt_d = tx_cnt_q;
    cti_d    = cti_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (buf_size != '0) begin
            start_d  = start_adr;
            size_d   = buf_size;
            burst_d  = eff_burst_c;
            tx_cnt_d = '0;
            busy_d   = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            done_d   = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (free_c >= len_c) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          adr_d   = start_q + (WB_AW'(tx_cnt_q) << STEP_SH);
          beat_d  = BL_W'(len_c);
          cti_d   = (len_c == WB_AW'(1)) ? CTI_EOB : CTI_INC;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        if (err_beat_c) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (ack_beat_c) begin
          tx_cnt_d = tx_inc_c;
          adr_d    = adr_q + WB_AW'(STEP);
          beat_d   = beat_q - BL_W'(1);
          if (beat_q == BL_W'(1)) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            cti_d = CTI_CLASSIC;
            if (WB_AW'(tx_inc_c) == size_q) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (beat_q == BL_W'(2)) begin
            cti_d = CTI_EOB;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      start_q  <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      tx_cnt_q <= '0;
      cti_q    <= CTI_CLASSIC;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      start_q  <= start_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      tx_cnt_q <= tx_cnt_d;
      cti_q    <= cti_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = BTE_LINEAR;
  assign fifo_d    = wbm_dat_i;
  assign fifo_wr   = ack_beat_c;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tx_cnt    = tx_cnt_q;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Directed bench for wb_stream_writer_ctrl with a zero-wait burst slave model.
module tb_wb_stream_writer_ctrl;
  import wb_stream_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned FAW = 4;
  localparam logic [31:0] DKEY = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0]   wbm_adr_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [DW/8-1:0] wbm_sel_o;
  logic            wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]      wbm_cti_o;
  logic [1:0]      wbm_bte_o;
  logic [DW-1:0]   wbm_dat_i;
  logic            wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [DW-1:0]   fifo_d;
  logic            fifo_wr;
  logic [FAW:0]    fifo_cnt;
  logic            enable;
  logic [AW-1:0]   start_adr, buf_size, burst_size;
  logic            busy, done;
  logic [DW-1:0]   tx_cnt;

  always #5 clk = ~clk;

  wb_stream_writer_ctrl #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW), .MAX_BURST_LEN(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .done(done), .tx_cnt(tx_cnt)
  );

  // Slave: acks every strobed cycle; optionally errors on a chosen beat (1-based)
  int   err_at;
  int   beat_no;
  logic beat_clr;
  logic err_hit;
  assign err_hit   = (err_at != 0) && (beat_no + 1 == err_at);
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !err_hit;
  assign wbm_err_i = wbm_cyc_o && wbm_stb_o && err_hit;
  assign wbm_dat_i = wbm_adr_o ^ DKEY;
  assign wbm_rty_i = 1'b0;

  // Acked-beat counter for the slave's error injection
  always @(posedge clk) begin
    if (beat_clr) beat_no <= 0;
    else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) beat_no <= beat_no + 1;
  end

  int errors = 0;
  int checks = 0;

  // Monitor state for the transfer in flight
  logic [31:0] m_start;
  int          m_size, m_blen;
  int          words, bursts, bstart, jb, done_seen;
  logic        cyc_prev;
  logic [31:0] last_adr;

  typedef struct {
    logic [31:0] start;
    int          size;
    int          burst;
    int          blen;
    int          nbursts;
    logic [31:0] last_adr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample on the falling edge and check any acked beat
  task automatic step();
    int          len;
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    @(negedge clk);
    if (wbm_cyc_o && !cyc_prev) begin
      bursts++;
      bstart = words;
      jb     = 0;
    end
    if (done) done_seen++;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      len     = (m_size - bstart < m_blen) ? (m_size - bstart) : m_blen;
      exp_adr = m_start + 32'(words * 4);
      exp_cti = (jb == len - 1) ? 3'b111 : 3'b010;
      chk("beat_adr", 64'(wbm_adr_o), 64'(exp_adr));
      chk("beat_cti", 64'(wbm_cti_o), 64'(exp_cti));
      chk("beat_fifo_wr", 64'(fifo_wr), 64'(1));
      chk("beat_fifo_d", 64'(fifo_d), 64'(exp_adr ^ DKEY));
      last_adr = wbm_adr_o;
      words++;
      jb++;
    end
    cyc_prev = wbm_cyc_o;
  endtask

  task automatic start_xfer(input logic [31:0] sa, input int sz, input int bs, input int blen);
    m_start = sa; m_size = sz; m_blen = blen;
    words = 0; bursts = 0; done_seen = 0; bstart = 0; jb = 0;
    start_adr = sa; buf_size = 32'(sz); burst_size = 32'(bs);
    enable = 1'b1; beat_clr = 1'b1;
    step();
    enable = 1'b0; beat_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_seen == 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_pulse", 64'(done_seen), 64'(1));
  endtask

  initial begin
    int n;
    vecs[0] = '{32'h0000_1000,  8,   4,  4, 2, 32'h0000_101C};
    vecs[1] = '{32'h0000_1000, 10,   4,  4, 3, 32'h0000_1024};
    vecs[2] = '{32'h0000_2000,  3,   0,  1, 3, 32'h0000_2008};
    vecs[3] = '{32'h0000_3000, 20, 100, 16, 2, 32'h0000_304C};
    vecs[4] = '{32'hFFFF_FFF8,  4,   4,  4, 1, 32'h0000_0004};
    vecs[5] = '{32'h0000_0400, 16,  16, 16, 1, 32'h0000_043C};

    rst = 1'b1; enable = 1'b0; start_adr = '0; buf_size = '0; burst_size = '0;
    fifo_cnt = '0; err_at = 0; beat_clr = 1'b1; cyc_prev = 1'b0;
    m_start = '0; m_size = 0; m_blen = 1; words = 0; bursts = 0; bstart = 0; jb = 0;
    done_seen = 0; last_adr = '0;
    repeat (3) step();

    // Reset state
    chk("rst_cyc", 64'(wbm_cyc_o), 64'(0));
    chk("rst_stb", 64'(wbm_stb_o), 64'(0));
    chk("rst_cti", 64'(wbm_cti_o), 64'(0));
    chk("rst_adr", 64'(wbm_adr_o), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_tx_cnt", 64'(tx_cnt), 64'(0));
    chk("rst_fifo_wr", 64'(fifo_wr), 64'(0));
    chk("tie_we", 64'(wbm_we_o), 64'(0));
    chk("tie_sel", 64'(wbm_sel_o), 64'(4'hF));
    chk("tie_bte", 64'(wbm_bte_o), 64'(0));
    chk("tie_dat", 64'(wbm_dat_o), 64'(0));
    rst = 1'b0; beat_clr = 1'b0;
    step();

    // Zero-length request: done only
    start_xfer(32'h800, 0, 4, 4);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    step();
    chk("zero_done_clear", 64'(done), 64'(0));
    chk("zero_cyc", 64'(wbm_cyc_o), 64'(0));

    // Table-driven full transfers with an empty FIFO
    for (int i = 0; i < 6; i++) begin
      start_xfer(vecs[i].start, vecs[i].size, vecs[i].burst, vecs[i].blen);
      chk("lat_busy", 64'(busy), 64'(1));
      chk("lat_cyc_early", 64'(wbm_cyc_o), 64'(0));
      step();
      chk("lat_cyc", 64'(wbm_cyc_o), 64'(1));
      wait_done(500);
      chk("xfer_busy_end", 64'(busy), 64'(0));
      chk("xfer_tx_cnt", 64'(tx_cnt), 64'(vecs[i].size));
      chk("xfer_words", 64'(words), 64'(vecs[i].size));
      chk("xfer_bursts", 64'(bursts), 64'(vecs[i].nbursts));
      chk("xfer_last_adr", 64'(last_adr), 64'(vecs[i].last_adr));
      step();
      chk("xfer_done_one_cycle", 64'(done), 64'(0));
    end

    // FIFO back-pressure: 2 free slots < burst of 4 holds the engine in WAIT
    fifo_cnt = 5'd14;
    start_xfer(32'h5000, 8, 4, 4);
    repeat (4) step();
    chk("bp_cyc_held", 64'(wbm_cyc_o), 64'(0));
    chk("bp_busy", 64'(busy), 64'(1));
    chk("bp_words", 64'(words), 64'(0));
    fifo_cnt = 5'd12;
    n = 0;
    while (!wbm_cyc_o && n < 6) begin
      step();
      n++;
    end
    chk("bp_issue_delay", 64'((n >= 1) && (n <= 2)), 64'(1));
    wait_done(500);
    chk("bp_tx_cnt", 64'(tx_cnt), 64'(8));
    chk("bp_bursts", 64'(bursts), 64'(2));
    fifo_cnt = '0;
    step();

    // Bus error on beat 3 of the first burst
    err_at = 3;
    start_xfer(32'h6000, 8, 4, 4);
    n = 0;
    while (!wbm_err_i && n < 20) begin
      step();
      n++;
    end
    chk("err_seen", 64'(wbm_err_i), 64'(1));
    chk("err_no_fifo_wr", 64'(fifo_wr), 64'(0));
    step();
    chk("err_cyc_drop", 64'(wbm_cyc_o), 64'(0));
    chk("err_stb_drop", 64'(wbm_stb_o), 64'(0));
    chk("err_done", 64'(done), 64'(1));
    chk("err_busy", 64'(busy), 64'(0));
    chk("err_tx_cnt", 64'(tx_cnt), 64'(2));
    chk("err_words", 64'(words), 64'(2));
    err_at = 0;
    step();
    chk("err_idle_cyc", 64'(wbm_cyc_o), 64'(0));

    // Enable held during a transfer is ignored; then reset mid-burst
    start_xfer(32'h7000, 32, 8, 8);
    start_adr = 32'h9000;
    enable    = 1'b1;
    n = 0;
    while (words < 3 && n < 50) begin
      step();
      n++;
    end
    chk("hold_words", 64'(words), 64'(3));
    chk("hold_tx_cnt", 64'(tx_cnt), 64'(2));
    chk("hold_bursts", 64'(bursts), 64'(1));
    chk("hold_busy", 64'(busy), 64'(1));
    chk("hold_cyc", 64'(wbm_cyc_o), 64'(1));
    rst    = 1'b1;
    enable = 1'b0;
    step();
    chk("mid_rst_cyc", 64'(wbm_cyc_o), 64'(0));
    chk("mid_rst_stb", 64'(wbm_stb_o), 64'(0));
    chk("mid_rst_fifo_wr", 64'(fifo_wr), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_tx_cnt", 64'(tx_cnt), 64'(0));
    rst = 1'b0;
    repeat (2) step();
    chk("post_rst_cyc", 64'(wbm_cyc_o), 64'(0));
    chk("post_rst_words", 64'(words), 64'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
